// File: rtl/branch_resolve.sv
// Execute-stage control-flow resolver: evaluates branch/JAL/JALR conditions, computes
// target and link, checks the frontend prediction and registers the result in one stage.
module branch_resolve #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic             pred_taken,
  input  logic [XLEN-1:0]  pred_target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             is_cf,
  output logic             taken,
  output logic [XLEN-1:0]  target,
  output logic [XLEN-1:0]  link,
  output logic             mispredict,
  output logic             misalign,
  output logic             illegal,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  function automatic logic br_cond(input logic [2:0] f3,
                                   input logic signed [XLEN-1:0] a,
                                   input logic signed [XLEN-1:0] b);
    logic r;
    case (f3)
      3'b000:  r = (a == b);
      3'b001:  r = (a != b);
      3'b100:  r = (a < b);
      3'b101:  r = (a >= b);
      3'b110:  r = ($unsigned(a) < $unsigned(b));
      3'b111:  r = ($unsigned(a) >= $unsigned(b));
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  logic signed [XLEN-1:0] rs1_s, rs2_s;
  logic [6:0]      opcode_p0;
  logic [2:0]      funct3_p0;
  logic [XLEN-1:0] link_p0, pc_imm_p0, jalr_sum_p0, jalr_tgt_p0, target_p0;
  logic            is_cf_p0, taken_p0, illegal_p0, misalign_p0, mispredict_p0;

  logic            vld_p1, is_cf_p1, taken_p1, illegal_p1, misalign_p1, mispredict_p1;
  logic [XLEN-1:0] target_p1, link_p1;
  logic [CNT_W-1:0] branch_cnt_q, mispred_cnt_q;
  logic            accept, fire;
  logic            unused_bits;

  // Stage p0: combinational resolve of the incoming beat
  assign rs1_s       = rs1;
  assign rs2_s       = rs2;
  assign opcode_p0   = instr[6:0];
  assign funct3_p0   = instr[14:12];
  assign link_p0     = pc + XLEN'(4);
  assign pc_imm_p0   = pc + imm;
  assign jalr_sum_p0 = rs1 + imm;
  assign jalr_tgt_p0 = {jalr_sum_p0[XLEN-1:1], 1'b0};
  assign unused_bits = ^{instr[31:15], instr[11:7], jalr_sum_p0[0]};

  always_comb begin
    is_cf_p0   = 1'b0;
    taken_p0   = 1'b0;
    illegal_p0 = 1'b0;
    target_p0  = link_p0;
    case (opcode_p0)
      OP_BRANCH: begin
        is_cf_p0   = 1'b1;
        illegal_p0 = (funct3_p0 == 3'b010) || (funct3_p0 == 3'b011);
        taken_p0   = br_cond(funct3_p0, rs1_s, rs2_s);
        if (taken_p0) target_p0 = pc_imm_p0;
      end
      OP_JAL: begin
        is_cf_p0  = 1'b1;
        taken_p0  = 1'b1;
        target_p0 = pc_imm_p0;
      end
      OP_JALR: begin
        is_cf_p0  = 1'b1;
        taken_p0  = 1'b1;
        target_p0 = jalr_tgt_p0;
      end
      default: ;
    endcase
  end

  assign misalign_p0   = taken_p0 && target_p0[1];
  assign mispredict_p0 = is_cf_p0 ? ((pred_taken != taken_p0) ||
                                     (taken_p0 && (pred_target != target_p0)))
                                  : pred_taken;

  assign in_ready = !vld_p1 || out_ready;
  assign accept   = in_valid && in_ready;
  assign fire     = vld_p1 && out_ready;

  // Stage p1: registered result, counters bump on the output handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1        <= 1'b0;
      is_cf_p1      <= 1'b0;
      taken_p1      <= 1'b0;
      illegal_p1    <= 1'b0;
      misalign_p1   <= 1'b0;
      mispredict_p1 <= 1'b0;
      target_p1     <= '0;
      link_p1       <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (fire && !flush) begin
        if (is_cf_p1)      branch_cnt_q  <= branch_cnt_q + CNT_W'(1);
        if (mispredict_p1) mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
      end
      if (flush)         vld_p1 <= 1'b0;
      else if (in_ready) vld_p1 <= in_valid;
      if (accept && !flush) begin
        is_cf_p1      <= is_cf_p0;
        taken_p1      <= taken_p0;
        illegal_p1    <= illegal_p0;
        misalign_p1   <= misalign_p0;
        mispredict_p1 <= mispredict_p0;
        target_p1     <= target_p0;
        link_p1       <= link_p0;
      end
    end
  end

  assign out_valid   = vld_p1;
  assign is_cf       = is_cf_p1;
  assign taken       = taken_p1;
  assign illegal     = illegal_p1;
  assign misalign    = misalign_p1;
  assign mispredict  = mispredict_p1;
  assign target      = target_p1;
  assign link        = link_p1;
  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: a 32-bit and a 64-bit (4-bit counter) instance share control
// inputs and are scored against a queue-based reference model.
module tb_branch_resolve;

  typedef struct packed {
    logic        is_cf;
    logic        taken;
    logic [63:0] target;
    logic [63:0] link;
    logic        mispredict;
    logic        misalign;
    logic        illegal;
  } res_t;

  localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111, ALU = 7'b0110011;

  logic clk = 1'b0;
  logic rst, flush, in_valid, out_ready, pred_taken;
  logic [31:0] instr;
  logic [63:0] pc_s, imm_s, rs1_s, rs2_s, ptgt_s;

  logic        in_ready_a, out_valid_a, is_cf_a, taken_a, mispredict_a, misalign_a, illegal_a;
  logic [31:0] target_a, link_a, branch_cnt_a, mispred_cnt_a;
  logic        in_ready_b, out_valid_b, is_cf_b, taken_b, mispredict_b, misalign_b, illegal_b;
  logic [63:0] target_b, link_b;
  logic [3:0]  branch_cnt_b, mispred_cnt_b;

  res_t qa[$], qb[$];
  logic [31:0] mba, mma;
  logic [3:0]  mbb, mmb;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  branch_resolve #(.XLEN(32), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .instr(instr), .pc(pc_s[31:0]), .imm(imm_s[31:0]), .rs1(rs1_s[31:0]), .rs2(rs2_s[31:0]),
    .pred_taken(pred_taken), .pred_target(ptgt_s[31:0]), .out_valid(out_valid_a),
    .out_ready(out_ready), .is_cf(is_cf_a), .taken(taken_a), .target(target_a), .link(link_a),
    .mispredict(mispredict_a), .misalign(misalign_a), .illegal(illegal_a),
    .branch_cnt(branch_cnt_a), .mispred_cnt(mispred_cnt_a));

  branch_resolve #(.XLEN(64), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .instr(instr), .pc(pc_s), .imm(imm_s), .rs1(rs1_s), .rs2(rs2_s),
    .pred_taken(pred_taken), .pred_target(ptgt_s), .out_valid(out_valid_b),
    .out_ready(out_ready), .is_cf(is_cf_b), .taken(taken_b), .target(target_b), .link(link_b),
    .mispredict(mispredict_b), .misalign(misalign_b), .illegal(illegal_b),
    .branch_cnt(branch_cnt_b), .mispred_cnt(mispred_cnt_b));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3);
    return {17'd0, f3, 5'd0, op};
  endfunction

  // Architectural meaning of one beat, evaluated with plain wide arithmetic and masking
  function automatic res_t ref_model(input int xl, input logic [31:0] ins,
      input logic [63:0] pc, input logic [63:0] imm, input logic [63:0] a,
      input logic [63:0] b, input logic pt, input logic [63:0] ptgt);
    res_t r;
    logic [63:0] mask, ua, ub;
    longint sa, sb;
    logic [2:0] f3;
    logic cond;
    r    = '0;
    cond = 1'b0;
    mask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    ua = a & mask;
    ub = b & mask;
    sa = (xl == 64) ? longint'(a) : longint'(int'(a[31:0]));
    sb = (xl == 64) ? longint'(b) : longint'(int'(b[31:0]));
    f3 = ins[14:12];
    r.link   = (pc + 64'd4) & mask;
    r.target = r.link;
    case (ins[6:0])
      BR: begin
        r.is_cf = 1'b1;
        case (f3)
          3'd0: cond = (ua == ub);
          3'd1: cond = (ua != ub);
          3'd4: cond = (sa < sb);
          3'd5: cond = (sa >= sb);
          3'd6: cond = (ua < ub);
          3'd7: cond = (ua >= ub);
          default: r.illegal = 1'b1;
        endcase
        r.taken = cond;
        if (cond) r.target = (pc + imm) & mask;
      end
      JAL:  begin r.is_cf = 1'b1; r.taken = 1'b1; r.target = (pc + imm) & mask; end
      JALR: begin r.is_cf = 1'b1; r.taken = 1'b1; r.target = ((a + imm) & mask) & ~64'd1; end
      default: ;
    endcase
    r.misalign   = r.taken && r.target[1];
    r.mispredict = r.is_cf ? ((pt != r.taken) || (r.taken && ((ptgt & mask) != r.target))) : pt;
    return r;
  endfunction

  task automatic check_outputs();
    res_t e;
    chk("a_vld", 64'(out_valid_a), 64'(qa.size() != 0));
    if (qa.size() != 0) begin
      e = qa[0];
      chk("a_is_cf", 64'(is_cf_a), 64'(e.is_cf));
      chk("a_taken", 64'(taken_a), 64'(e.taken));
      chk("a_target", 64'(target_a), e.target);
      chk("a_link", 64'(link_a), e.link);
      chk("a_mispred", 64'(mispredict_a), 64'(e.mispredict));
      chk("a_misalign", 64'(misalign_a), 64'(e.misalign));
      chk("a_illegal", 64'(illegal_a), 64'(e.illegal));
    end
    chk("a_bcnt", 64'(branch_cnt_a), 64'(mba));
    chk("a_mcnt", 64'(mispred_cnt_a), 64'(mma));
    chk("b_vld", 64'(out_valid_b), 64'(qb.size() != 0));
    if (qb.size() != 0) begin
      e = qb[0];
      chk("b_is_cf", 64'(is_cf_b), 64'(e.is_cf));
      chk("b_taken", 64'(taken_b), 64'(e.taken));
      chk("b_target", target_b, e.target);
      chk("b_link", link_b, e.link);
      chk("b_mispred", 64'(mispredict_b), 64'(e.mispredict));
      chk("b_misalign", 64'(misalign_b), 64'(e.misalign));
      chk("b_illegal", 64'(illegal_b), 64'(e.illegal));
    end
    chk("b_bcnt", 64'(branch_cnt_b), 64'(mbb));
    chk("b_mcnt", 64'(mispred_cnt_b), 64'(mmb));
  endtask

  // Inputs are already driven; advance one clock, update the model, then check
  task automatic cycle();
    res_t e;
    logic rdy;
    #1;
    rdy = (qa.size() == 0) || out_ready;
    chk("a_in_ready", 64'(in_ready_a), 64'(rdy));
    chk("b_in_ready", 64'(in_ready_b), 64'((qb.size() == 0) || out_ready));
    @(posedge clk);
    if (rst) begin
      qa.delete(); qb.delete();
      mba = '0; mma = '0; mbb = '0; mmb = '0;
    end else begin
      if (!flush && out_ready && qa.size() != 0) begin
        e = qa.pop_front();
        if (e.is_cf) mba++;
        if (e.mispredict) mma++;
      end
      if (!flush && out_ready && qb.size() != 0) begin
        e = qb.pop_front();
        if (e.is_cf) mbb++;
        if (e.mispredict) mmb++;
      end
      if (flush) begin
        qa.delete(); qb.delete();
      end else if (in_valid && rdy) begin
        qa.push_back(ref_model(32, instr, pc_s, imm_s, rs1_s, rs2_s, pred_taken, ptgt_s));
        qb.push_back(ref_model(64, instr, pc_s, imm_s, rs1_s, rs2_s, pred_taken, ptgt_s));
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic drive(input logic [31:0] ins, input logic [63:0] pc, input logic [63:0] imm,
                       input logic [63:0] a, input logic [63:0] b, input logic pt,
                       input logic [63:0] ptgt);
    instr = ins; pc_s = pc; imm_s = imm; rs1_s = a; rs2_s = b;
    pred_taken = pt; ptgt_s = ptgt;
  endtask

  task automatic beat();
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] b0, m0, hold;
    res_t g;
    int sel;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    mba = '0; mma = '0; mbb = '0; mmb = '0;
    drive(32'h0, 64'h0, 64'h0, 64'h0, 64'h0, 1'b0, 64'h0);
    cycle(); cycle();
    chk("rst_vld", 64'(out_valid_a), 64'd0);
    chk("rst_target", 64'(target_a), 64'd0);
    chk("rst_link", 64'(link_a), 64'd0);
    chk("rst_bcnt", 64'(branch_cnt_a), 64'd0);
    chk("rst_mcnt", 64'(mispred_cnt_a), 64'd0);
    rst = 1'b0;
    cycle();

    drive(mk(BR, 3'b100), 64'h100, 64'h40, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0);
    beat();
    chk("blt_taken", 64'(taken_a), 64'd1);
    chk("blt_target", 64'(target_a), 64'h140);
    chk("blt_mispred", 64'(mispredict_a), 64'd1);
    cycle();
    chk("blt_mcnt", 64'(mispred_cnt_a), 64'd1);

    drive(mk(BR, 3'b110), 64'h100, 64'h40, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0);
    beat();
    chk("bltu_taken", 64'(taken_a), 64'd0);
    chk("bltu_target", 64'(target_a), 64'h104);
    chk("bltu_mispred", 64'(mispredict_a), 64'd0);
    cycle();

    drive(mk(JALR, 3'b000), 64'h200, 64'h10, 64'h1001, 64'h0, 1'b1, 64'h1010);
    beat();
    chk("jalr_target", 64'(target_a), 64'h1010);
    chk("jalr_link", 64'(link_a), 64'h204);
    chk("jalr_mispred", 64'(mispredict_a), 64'd0);
    chk("jalr_misalign", 64'(misalign_a), 64'd0);
    cycle();
    drive(mk(JALR, 3'b000), 64'h200, 64'h12, 64'h1001, 64'h0, 1'b1, 64'h1010);
    beat();
    chk("jalr2_target", 64'(target_a), 64'h1012);
    chk("jalr2_misalign", 64'(misalign_a), 64'd1);
    chk("jalr2_mispred", 64'(mispredict_a), 64'd1);
    cycle();

    b0 = branch_cnt_a; m0 = mispred_cnt_a;
    drive(mk(ALU, 3'b000), 64'h300, 64'h0, 64'h5, 64'h6, 1'b1, 64'h0);
    beat();
    chk("add_is_cf", 64'(is_cf_a), 64'd0);
    chk("add_target", 64'(target_a), 64'h304);
    chk("add_mispred", 64'(mispredict_a), 64'd1);
    cycle();
    chk("add_bcnt", 64'(branch_cnt_a), 64'(b0));
    chk("add_mcnt", 64'(mispred_cnt_a), 64'(m0 + 32'd1));

    drive(mk(JAL, 3'b000), 64'hFFFF_FFFF_FFFF_FFFC, 64'h8, 64'h0, 64'h0, 1'b1, 64'h4);
    beat();
    chk("wrap_target_a", 64'(target_a), 64'h4);
    chk("wrap_target_b", target_b, 64'h4);
    cycle();
    drive(mk(BR, 3'b101), 64'h400, 64'h20, 64'h8000_0000_0000_0000, 64'h0, 1'b0, 64'h0);
    beat();
    chk("bge64_taken", 64'(taken_b), 64'd0);
    cycle();
    drive(mk(BR, 3'b010), 64'h400, 64'h20, 64'h7, 64'h7, 1'b0, 64'h0);
    beat();
    chk("ill_illegal", 64'(illegal_a), 64'd1);
    chk("ill_taken", 64'(taken_a), 64'd0);
    chk("ill_is_cf", 64'(is_cf_a), 64'd1);
    cycle();

    // Stall: A is held for three cycles while B waits at the input
    b0 = branch_cnt_a;
    out_ready = 1'b0;
    drive(mk(BR, 3'b000), 64'h500, 64'h80, 64'h9, 64'h9, 1'b1, 64'h580);
    beat();
    hold = target_a;
    drive(mk(JAL, 3'b000), 64'h600, 64'h100, 64'h0, 64'h0, 1'b0, 64'h0);
    in_valid = 1'b1;
    repeat (3) begin
      cycle();
      chk("stall_in_ready", 64'(in_ready_a), 64'd0);
      chk("stall_hold", 64'(target_a), 64'(hold));
    end
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    chk("stall_bcnt", 64'(branch_cnt_a), 64'(b0 + 32'd2));

    // Flush with a held result, out_ready=1 and a new beat on the input
    out_ready = 1'b0;
    drive(mk(JAL, 3'b000), 64'h700, 64'h40, 64'h0, 64'h0, 1'b0, 64'h0);
    beat();
    b0 = branch_cnt_a; m0 = mispred_cnt_a;
    drive(mk(JAL, 3'b000), 64'h800, 64'h40, 64'h0, 64'h0, 1'b0, 64'h0);
    in_valid = 1'b1; out_ready = 1'b1; flush = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_vld", 64'(out_valid_a), 64'd0);
    chk("flush_bcnt", 64'(branch_cnt_a), 64'(b0));
    chk("flush_mcnt", 64'(mispred_cnt_a), 64'(m0));
    cycle();
    chk("flush_drop", 64'(out_valid_a), 64'd0);

    // Reset asserted while a result is stalled
    out_ready = 1'b0;
    drive(mk(JAL, 3'b000), 64'h900, 64'h40, 64'h0, 64'h0, 1'b0, 64'h0);
    beat();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst2_vld", 64'(out_valid_a), 64'd0);
    chk("rst2_bcnt", 64'(branch_cnt_a), 64'd0);
    chk("rst2_mcnt", 64'(mispred_cnt_a), 64'd0);

    repeat (3000) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 5)       instr = mk(BR, 3'($urandom_range(0, 7)));
      else if (sel == 5) instr = mk(JAL, 3'($urandom_range(0, 7)));
      else if (sel == 6) instr = mk(JALR, 3'd0);
      else               instr = $urandom;
      pc_s  = {$urandom, $urandom};
      imm_s = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : 64'($urandom_range(0, 4096));
      rs1_s = {$urandom, $urandom};
      rs2_s = ($urandom_range(0, 3) == 0) ? rs1_s : {$urandom, $urandom};
      g = ref_model(64, instr, pc_s, imm_s, rs1_s, rs2_s, 1'b0, 64'h0);
      pred_taken = ($urandom_range(0, 1) == 1) ? g.taken : 1'($urandom);
      ptgt_s     = ($urandom_range(0, 1) == 1) ? g.target : {$urandom, $urandom};
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 19) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Parametrised successor to the execute-stage branch comparator.
- Resolves conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU), JAL and JALR in one registered stage.
- Computes the target and link address and checks the frontend prediction, emitting a redirect on mispredict.
- Uses a valid/ready handshake on both sides, supports flush, and keeps resolved-branch and mispredict counters.

Parameters:
- XLEN, 32, operand, PC and immediate width (32 or 64).
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  kill the held result and drop any input accepted this cycle
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept a beat
- instr  in  32  instruction word; opcode [6:0], funct3 [14:12]
- pc  in  XLEN  instruction PC
- imm  in  XLEN  sign-extended B/J/I immediate, decoded upstream
- rs1  in  XLEN  source operand 1
- rs2  in  XLEN  source operand 2
- pred_taken  in  1  frontend predicted taken
- pred_target  in  XLEN  frontend predicted target
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- is_cf  out  1  beat was a control-flow instruction (branch/JAL/JALR)
- taken  out  1  resolved direction
- target  out  XLEN  resolved target; pc+4 when not taken
- link  out  XLEN  pc+4, the rd value for JAL/JALR
- mispredict  out  1  prediction wrong; redirect required
- misalign  out  1  taken target has bit1 set (no C extension)
- illegal  out  1  BRANCH opcode with funct3 010 or 011
- branch_cnt  out  CNT_W  resolved control-flow beats
- mispred_cnt  out  CNT_W  mispredicted beats

Behaviour:
- Reset:
  - out_valid=0; all result outputs=0.
  - branch_cnt=0, mispred_cnt=0.
  - in_ready is driven by its equation (1 during and after reset).
- Handshake:
  - in_ready = !out_valid || out_ready.
  - Accept when in_valid && in_ready; the result is registered, so out_valid rises the next cycle (latency 1).
  - Full throughput when out_ready stays high.
  - Result outputs stay stable while out_valid && !out_ready.
- Decode by opcode:
  - 1100011 is BRANCH.
  - 1101111 is JAL.
  - 1100111 is JALR.
  - Anything else is non-CF: is_cf=0, taken=0, target=pc+4.
- BRANCH compares:
  - BEQ: rs1==rs2.
  - BNE: rs1!=rs2.
  - BLT and BGE: signed comparison.
  - BLTU and BGEU: unsigned comparison.
  - funct3 010 or 011: illegal=1, taken=0, is_cf=1.
- Targets:
  - Taken branch: pc+imm.
  - JAL: pc+imm, taken=1.
  - JALR: (rs1+imm) with bit0 cleared, taken=1.
  - All adds are modulo 2^XLEN, so wrap-around is legal.
- misalign = taken && target[1]. The target is still reported; there is no internal trap.
- mispredict:
  - CF beat: (pred_taken != taken) || (taken && pred_target != target).
  - Non-CF beat: pred_taken.
- Counters:
  - Update on the output handshake (out_valid && out_ready), once per beat.
  - branch_cnt increments if is_cf; mispred_cnt increments if mispredict.
  - Both wrap modulo 2^CNT_W.
- flush:
  - Next cycle out_valid=0.
  - Any beat accepted in the same cycle is discarded.
  - A held result is dropped and not counted, even if out_ready=1 in the flush cycle.
  - Flush overrides a simultaneous accept.
- rst overrides flush and all handshakes. Reset asserted mid-stall clears out_valid and the counters next cycle.

Test Plan:
- BLT rs1=0xFFFF_FFFF, rs2=1, pc=0x100, imm=0x40, pred_taken=0 -> taken=1, target=0x140, mispredict=1, mispred_cnt=1; the same operands on BLTU give taken=0, target=0x104, mispredict=0.
- JALR rs1=0x1001, imm=0x10, pc=0x200, pred_taken=1, pred_target=0x1010 -> target=0x1010, link=0x204, mispredict=0, misalign=0; with imm=0x12 -> target=0x1012, misalign=1, mispredict=1.
- Back-to-back beats with out_ready held 0 for 3 cycles -> in_ready=0, outputs frozen; when out_ready=1, one beat completes per cycle and branch_cnt increases by exactly 2.
- Flush while a result is held with out_ready=1 and in_valid=1 -> out_valid=0 next cycle, counters unchanged, the new beat dropped.
- ADD instr with pred_taken=1, pc=0x300 -> is_cf=0, target=0x304, mispredict=1, branch_cnt unchanged, mispred_cnt+1.
- XLEN=64, BGE rs1=0x8000_0000_0000_0000, rs2=0 -> taken=0; funct3=010 -> illegal=1, taken=0; pc=0xFFFF_FFFC, imm=8 at XLEN=32 -> target=0x4.
